// File: rtl/core_mem_port.sv
// Per-core request front-end sitting upstream of the 3-core RAM arbiter.
// Turns a one-cycle load/store pulse into a level-held rden/wren request, waits for the
// per-core grant, holds the request while the RAM result settles, captures read data,
// pulses done, then waits for the grant to drop before accepting another access.
module core_mem_port #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned HOLD_CYC = 3,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic              mem_acq,
    input  logic [DATA_W-1:0] mem_dq
);

    localparam int unsigned CntMax = (HOLD_CYC > TIMEOUT) ? HOLD_CYC : TIMEOUT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] CntSat      = CntW'(CntMax);
    localparam logic [CntW-1:0] HoldLast    = CntW'(HOLD_CYC - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StReq, StHold, StDone, StCool} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [CntW-1:0]   cnt_inc;
    logic              timeout_hit;
    logic              hold_last;
    logic              req_on;

    // Saturating counter shared by the grant wait (REQ) and the settle window (HOLD).
    always_comb begin
        cnt_inc     = (cnt_q == CntSat) ? cnt_q : cnt_q + CntW'(1);
        timeout_hit = (TIMEOUT != 0) && (cnt_q == TimeoutLast);
        hold_last   = (cnt_q == HoldLast);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic; a grant in the final wait cycle beats the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (cpu_rd || cpu_wr) state_d = StReq;
            StReq: begin
                if (mem_acq) begin
                    state_d = StHold;
                end else if (timeout_hit) begin
                    state_d = StDone;
                end
            end
            StHold: if (hold_last) state_d = StDone;
            StDone: state_d = StCool;
            // Lingering grant from the arbiter must clear before a new access.
            StCool: if (!mem_acq) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Request capture, counting, error flag and read-data capture.
    always_comb begin
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        din_d   = din_q;
        rdata_d = rdata_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (cpu_wr) begin
                    // Write wins over a simultaneous read.
                    wr_d   = 1'b1;
                    err_d  = 1'b0;
                    addr_d = cpu_addr;
                    din_d  = cpu_wdata;
                end else if (cpu_rd) begin
                    wr_d   = 1'b0;
                    err_d  = 1'b0;
                    addr_d = cpu_addr;
                end
            end
            StReq: begin
                if (mem_acq) begin
                    cnt_d = '0;
                end else if (timeout_hit) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StHold: begin
                if (hold_last) begin
                    if (!wr_q) rdata_d = mem_dq;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from the current state and registered request fields.
    always_comb begin
        req_on    = (state_q == StReq) || (state_q == StHold);
        cpu_busy  = (state_q != StIdle);
        cpu_done  = (state_q == StDone);
        cpu_err   = (state_q == StDone) && err_q;
        cpu_rdata = rdata_q;
        mem_rden  = req_on && !wr_q;
        mem_wren  = req_on && wr_q;
        mem_addr  = addr_q;
        mem_din   = din_q;
    end

endmodule
